apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_ctrl.sv | 132 +++++++++++++
 tb/tb_apb_master_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// Single-request APB master: turns a valid/ready request into an APB SETUP/ACCESS
// transfer and reports completion with a one-cycle response pulse.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // A zero TIMEOUT still needs a 1-bit counter to stay legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic              pwrite_nxt, psel_nxt, penable_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic              timeout_hit;

  assign req_ready   = (state == IDLE);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      paddr       <= paddr_nxt;
      pwrite      <= pwrite_nxt;
      pwdata      <= pwdata_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    paddr_nxt       = paddr;
    pwrite_nxt      = pwrite;
    pwdata_nxt      = pwdata;
    psel_nxt        = psel;
    penable_nxt     = penable;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    case (state)
      IDLE: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        if (req_valid) begin
          state_nxt  = SETUP;
          paddr_nxt  = req_addr;
          pwrite_nxt = req_write;
          pwdata_nxt = req_wdata;
          psel_nxt   = 1'b1;
          cnt_nxt    = '0;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
      end
      ACCESS: begin
        // A ready slave wins over a timeout expiring on the same edge.
        if (pready) begin
          state_nxt       = IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = pwrite ? '0 : prdata;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
        end else if (timeout_hit) begin
          state_nxt       = IDLE;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: a vector table of single transfers with a
// scripted slave, plus hand-written back-to-back and mid-transfer reset sequences.
module tb_apb_master_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Issue one request at a negedge in IDLE and play the slave until rsp_valid.
  task automatic applyStimulus(input vec_t v, input int idx);
    int  n;
    int  lat;
    bit  done;
    checkOutput($sformatf("v%0d_req_ready", idx), 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~v.addr;
    req_wdata = ~v.wdata;
    req_write = ~v.write;
    lat = 1;
    checkOutput($sformatf("v%0d_setup_psel_penable", idx), {62'd0, psel, penable}, 64'b10);
    checkOutput($sformatf("v%0d_setup_paddr", idx), 64'(paddr), 64'(v.addr));
    checkOutput($sformatf("v%0d_setup_pwrite", idx), 64'(pwrite), 64'(v.write));
    checkOutput($sformatf("v%0d_setup_pwdata", idx), 64'(pwdata), 64'(v.wdata));
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        done = 1;
        pready  = 1'b0;
        pslverr = 1'b1;
        prdata  = 32'hBAD0BAD0;
      end else begin
        n++;
        if (psel !== 1'b1 || penable !== 1'b1 || paddr !== v.addr ||
            pwdata !== v.wdata || pwrite !== v.write)
          checkOutput($sformatf("v%0d_access%0d_bus", idx, n),
                      {psel, penable, pwrite, paddr, pwdata},
                      {1'b1, 1'b1, v.write, v.addr, v.wdata});
        pready  = (n == v.waits + 1);
        prdata  = pready ? v.prdata : 32'hBAD0BAD0;
        pslverr = pready ? v.slverr : 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL v%0d_rsp_wait: actual=no rsp_valid expected=rsp_valid within 40 cycles", idx);
    end else begin
      checkOutput($sformatf("v%0d_access_cycles", idx), 64'(n), 64'(v.exp_acc));
      checkOutput($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_acc + 2));
      checkOutput($sformatf("v%0d_rsp_rdata", idx), 64'(rsp_rdata), 64'(v.exp_rdata));
      checkOutput($sformatf("v%0d_rsp_err_to", idx), {62'd0, rsp_err, rsp_timeout},
                  {62'd0, v.exp_err, v.exp_to});
      checkOutput($sformatf("v%0d_idle_bus", idx), {61'd0, psel, penable, req_ready}, 64'b001);
      checkOutput($sformatf("v%0d_idle_paddr_kept", idx), 64'(paddr), 64'(v.addr));
      @(negedge clk);
      checkOutput($sformatf("v%0d_rsp_pulse_end", idx), 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0,   32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 8'h24, 32'h0,        4,   32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0, 5};
    vecs[2] = '{1'b0, 8'h30, 32'h0,        0,   32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 8'h44, 32'h0,        100, 32'h55555555, 1'b0, 32'h0,        1'b1, 1'b1, 16};
    vecs[4] = '{1'b0, 8'h48, 32'h0,        15,  32'h0BADCAFE, 1'b0, 32'h0BADCAFE, 1'b0, 1'b0, 16};
    vecs[5] = '{1'b1, 8'h7F, 32'h01020304, 2,   32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 1'b0, 3};
    vecs[6] = '{1'b1, 8'hFF, 32'h89ABCDEF, 15,  32'h77777777, 1'b0, 32'h0,        1'b0, 1'b0, 16};

    // Reset state, with garbage on the slave side that must be ignored.
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFFFFFF;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata},
                64'd0);
    checkOutput("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_idle", {62'd0, req_ready, psel}, 64'b10);
    pready = 1'b0; pslverr = 1'b0; prdata = '0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    // Back-to-back: req_valid stays high; second request taken in the rsp_valid cycle.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h50; req_wdata = 32'h11112222;
    @(negedge clk);
    req_write = 1'b0; req_addr = 8'h54; req_wdata = 32'h0;
    checkOutput("b2b_first_setup_paddr", 64'(paddr), 64'h50);
    @(negedge clk);
    pready = 1'b1; prdata = 32'h33334444; pslverr = 1'b0;
    @(negedge clk);
    checkOutput("b2b_first_rsp", {61'd0, rsp_valid, req_ready, rsp_err}, 64'b110);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("b2b_second_setup", {62'd0, psel, penable}, 64'b10);
    checkOutput("b2b_second_paddr", 64'(paddr), 64'h54);
    checkOutput("b2b_no_extra_pulse", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    pready = 1'b0;
    checkOutput("b2b_second_rsp", {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, 32'h33334444});
    @(negedge clk);

    // Reset while waiting in ACCESS.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h60;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midreset_in_access", {62'd0, psel, penable}, 64'b11);
    #1 rst_n = 1'b0;
    #1 checkOutput("midreset_async_drop", {62'd0, psel, penable}, 64'b00);
    pready = 1'b1; prdata = 32'hDEADDEAD;
    @(negedge clk);
    rst_n = 1'b1;
    pready = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    checkOutput("midreset_no_rsp", 64'(n), 64'd0);
    checkOutput("midreset_ready", 64'(req_ready), 64'd1);
    applyStimulus(vecs[0], 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
